// File: rtl/ysyx_23060251_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_23060251_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060251_arb_pick.sv
// Two-way grant picker: round-robin on the preference pointer, or LSU-first fixed priority.
// Latency: combinational, zero cycles.
// Backpressure: none; at most one grant is returned and only for a valid requester.
// Build option: YSYX_23060251_ARB_RR_EN selects round-robin (adds the pref input).
module ysyx_23060251_arb_pick
  import ysyx_23060251_arb_pkg::*;
(
  input  logic   ifu_vld,
  input  logic   lsu_vld,
`ifdef YSYX_23060251_ARB_RR_EN
  input  owner_e pref,
`endif
  output logic   gnt_ifu,
  output logic   gnt_lsu
);

  // Resolve the grant; ties go to the preferred requester (RR) or to the LSU (fixed).
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
    if (ifu_vld && lsu_vld) begin
      gnt_lsu = (pref == OWN_LSU);
      gnt_ifu = (pref == OWN_IFU);
    end else begin
      gnt_ifu = ifu_vld;
      gnt_lsu = lsu_vld;
    end
`else
    gnt_lsu = lsu_vld;
    gnt_ifu = ifu_vld && !lsu_vld;
`endif
  end

endmodule

// File: rtl/ysyx_23060251_mem_arb.sv
// Shares one memory port between IFU (read-only) and LSU; one transaction outstanding, response routed to its owner.
// Latency: grant same cycle as request, m_req_valid next cycle, response passed through combinationally; 3 cycles minimum occupancy.
// Backpressure: req_ready only in IDLE; payload held while m_req_ready=0; m_resp_ready follows the owner's resp_ready.
// Build option: YSYX_23060251_ARB_RR_EN enables round-robin arbitration (default: LSU fixed priority).
module ysyx_23060251_mem_arb
  import ysyx_23060251_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                lsu_resp_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_wen,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_resp_valid,
  output logic                m_resp_ready,
  input  logic [DATA_W-1:0]   m_resp_data,
  input  logic                m_resp_err
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                req_en;
  logic                gnt_ifu, gnt_lsu;
  logic                to_ifu, to_lsu;
`ifdef YSYX_23060251_ARB_RR_EN
  owner_e              ptr_q, ptr_d;
`endif

  // Grants are only offered while idle and out of reset, so req_ready is 0 during reset.
  assign req_en = rst && (state_q == IDLE);

  ysyx_23060251_arb_pick u_pick (
    .ifu_vld (req_en && ifu_req_valid),
    .lsu_vld (req_en && lsu_req_valid),
`ifdef YSYX_23060251_ARB_RR_EN
    .pref    (ptr_q),
`endif
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu)
  );

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;

  // Next-state: capture the winner's payload in IDLE, hold it through SEND, release on the response handshake.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef YSYX_23060251_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_lsu) begin
          state_d = SEND;
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wstrb_d = lsu_req_wstrb;
`ifdef YSYX_23060251_ARB_RR_EN
          ptr_d   = OWN_IFU;
`endif
        end else if (gnt_ifu) begin
          state_d = SEND;
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
`ifdef YSYX_23060251_ARB_RR_EN
          ptr_d   = OWN_LSU;
`endif
        end
      end
      SEND: if (m_req_ready) state_d = WAIT;
      WAIT: if (m_resp_valid && m_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
`ifdef YSYX_23060251_ARB_RR_EN
      ptr_q   <= OWN_LSU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef YSYX_23060251_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign m_req_valid = (state_q == SEND);
  assign m_req_addr  = addr_q;
  assign m_req_wen   = wen_q;
  assign m_req_wdata = wdata_q;
  assign m_req_wstrb = wstrb_q;

  // Response routing: only the owner sees the response, and only while waiting for it.
  always_comb begin
    to_ifu         = (state_q == WAIT) && (owner_q == OWN_IFU);
    to_lsu         = (state_q == WAIT) && (owner_q == OWN_LSU);
    ifu_resp_valid = to_ifu && m_resp_valid;
    ifu_resp_data  = to_ifu ? m_resp_data : '0;
    ifu_resp_err   = to_ifu && m_resp_err;
    lsu_resp_valid = to_lsu && m_resp_valid;
    lsu_resp_data  = to_lsu ? m_resp_data : '0;
    lsu_resp_err   = to_lsu && m_resp_err;
    m_resp_ready   = (to_ifu && ifu_resp_ready) || (to_lsu && lsu_resp_ready);
  end

endmodule

// File: tb/tb_ysyx_23060251_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: transaction-level model compared every cycle, plus directed literal checks.
// Build with or without YSYX_23060251_ARB_RR_EN; expected grant order follows the same macro.
module tb_ysyx_23060251_mem_arb;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_wstrb;
  logic        m_req_valid, m_req_ready, m_req_wen, m_resp_valid, m_resp_ready, m_resp_err;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
  logic [3:0]  m_req_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_23060251_mem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_data(m_resp_data), .m_resp_err(m_resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // md_busy: a transaction has been accepted; md_sent: it has been handed downstream.
  logic        md_busy, md_sent, md_lsu;
  logic [31:0] md_addr, md_wdata;
  logic        md_wen;
  logic [3:0]  md_wstrb;
`ifdef YSYX_23060251_ARB_RR_EN
  logic        md_pref_lsu;
`endif
  logic e_ifu_rdy, e_lsu_rdy, e_mreq_v, e_mresp_rdy, e_ifu_rv, e_lsu_rv, lsu_wins;

  always_comb begin
`ifdef YSYX_23060251_ARB_RR_EN
    lsu_wins = lsu_req_valid && (!ifu_req_valid || md_pref_lsu);
`else
    lsu_wins = lsu_req_valid;
`endif
    e_lsu_rdy   = rst && !md_busy && lsu_wins;
    e_ifu_rdy   = rst && !md_busy && ifu_req_valid && !lsu_wins;
    e_mreq_v    = rst && md_busy && !md_sent;
    e_ifu_rv    = rst && md_busy && md_sent && !md_lsu && m_resp_valid;
    e_lsu_rv    = rst && md_busy && md_sent && md_lsu && m_resp_valid;
    e_mresp_rdy = rst && md_busy && md_sent && (md_lsu ? lsu_resp_ready : ifu_resp_ready);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_busy <= 1'b0; md_sent <= 1'b0; md_lsu <= 1'b0;
      md_addr <= '0; md_wen <= 1'b0; md_wdata <= '0; md_wstrb <= '0;
`ifdef YSYX_23060251_ARB_RR_EN
      md_pref_lsu <= 1'b1;
`endif
    end else if (!md_busy) begin
      if (e_lsu_rdy) begin
        md_busy <= 1'b1; md_lsu <= 1'b1;
        md_addr <= lsu_req_addr; md_wen <= lsu_req_wen;
        md_wdata <= lsu_req_wdata; md_wstrb <= lsu_req_wstrb;
`ifdef YSYX_23060251_ARB_RR_EN
        md_pref_lsu <= 1'b0;
`endif
      end else if (e_ifu_rdy) begin
        md_busy <= 1'b1; md_lsu <= 1'b0;
        md_addr <= ifu_req_addr; md_wen <= 1'b0; md_wdata <= '0; md_wstrb <= '0;
`ifdef YSYX_23060251_ARB_RR_EN
        md_pref_lsu <= 1'b1;
`endif
      end
    end else if (!md_sent) begin
      if (m_req_ready) md_sent <= 1'b1;
    end else if (m_resp_valid && e_mresp_rdy) begin
      md_busy <= 1'b0;
      md_sent <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("cyc_ifu_req_ready", {31'd0, ifu_req_ready}, {31'd0, e_ifu_rdy});
    chk("cyc_lsu_req_ready", {31'd0, lsu_req_ready}, {31'd0, e_lsu_rdy});
    chk("cyc_m_req_valid", {31'd0, m_req_valid}, {31'd0, e_mreq_v});
    chk("cyc_m_resp_ready", {31'd0, m_resp_ready}, {31'd0, e_mresp_rdy});
    chk("cyc_ifu_resp_valid", {31'd0, ifu_resp_valid}, {31'd0, e_ifu_rv});
    chk("cyc_lsu_resp_valid", {31'd0, lsu_resp_valid}, {31'd0, e_lsu_rv});
    if (e_mreq_v) begin
      chk("cyc_m_req_addr", m_req_addr, md_addr);
      chk("cyc_m_req_wen", {31'd0, m_req_wen}, {31'd0, md_wen});
      chk("cyc_m_req_wdata", m_req_wdata, md_wdata);
      chk("cyc_m_req_wstrb", {28'd0, m_req_wstrb}, {28'd0, md_wstrb});
    end
    if (e_ifu_rv) begin
      chk("cyc_ifu_resp_data", ifu_resp_data, m_resp_data);
      chk("cyc_ifu_resp_err", {31'd0, ifu_resp_err}, {31'd0, m_resp_err});
    end
    if (e_lsu_rv) begin
      chk("cyc_lsu_resp_data", lsu_resp_data, m_resp_data);
      chk("cyc_lsu_resp_err", {31'd0, lsu_resp_err}, {31'd0, m_resp_err});
    end
  end

  // Grant log (1 = LSU) for the contention test.
  logic log_en = 1'b0;
  logic gq[$];
  always @(negedge clk) begin
    if (log_en && ifu_req_valid && ifu_req_ready) gq.push_back(1'b0);
    if (log_en && lsu_req_valid && lsu_req_ready) gq.push_back(1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a downstream request, then accept it on the next edge.
  task automatic send_phase();
    int n = 0;
    m_req_ready = 1'b1;
    while (!m_req_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("send_wait_m_req_valid", {31'd0, m_req_valid}, 32'd1);
    cyc();
  endtask

  task automatic mem_txn(input logic [31:0] data, input logic err);
    send_phase();
    m_resp_valid = 1'b1;
    m_resp_data  = data;
    m_resp_err   = err;
    cyc();
    m_resp_valid = 1'b0;
    m_resp_err   = 1'b0;
  endtask

  logic exp_ord[4];

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = '0; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wstrb = '0; lsu_resp_ready = 1'b1;
    m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_data = '0; m_resp_err = 1'b0;

    // Reset state, with requests and a stray response present.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ifu_req_ready", {31'd0, ifu_req_ready}, 32'd0);
    chk("rst_lsu_req_ready", {31'd0, lsu_req_ready}, 32'd0);
    chk("rst_m_req_valid", {31'd0, m_req_valid}, 32'd0);
    chk("rst_m_resp_ready", {31'd0, m_resp_ready}, 32'd0);
    chk("rst_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd0);
    chk("rst_m_req_addr", m_req_addr, 32'd0);
    ifu_req_valid = 1'b0; m_resp_valid = 1'b0; m_req_ready = 1'b1;
    rst = 1'b1;
    cyc();

    // 1. Single IFU fetch.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    #1 chk("t1_ifu_req_ready", {31'd0, ifu_req_ready}, 32'd1);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
    chk("t1_m_req_valid", {31'd0, m_req_valid}, 32'd1);
    chk("t1_m_req_addr", m_req_addr, 32'h8000_0000);
    chk("t1_m_req_wen", {31'd0, m_req_wen}, 32'd0);
    cyc();
    m_resp_valid = 1'b1; m_resp_data = 32'h0000_0413;
    #1;
    chk("t1_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd1);
    chk("t1_ifu_resp_data", ifu_resp_data, 32'h0000_0413);
    chk("t1_ifu_resp_err", {31'd0, ifu_resp_err}, 32'd0);
    chk("t1_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd0);
    cyc();
    m_resp_valid = 1'b0;
    #1 chk("t1_ifu_resp_valid_done", {31'd0, ifu_resp_valid}, 32'd0);

    // 2. Continuous contention for four transactions.
    log_en = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) mem_txn(32'h0000_0100 + i, 1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1 log_en = 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("t2_grant_count", gq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk($sformatf("t2_grant_%0d_is_lsu", i), {31'd0, gq[i]}, {31'd0, exp_ord[i]});
    end

    // 3. Downstream backpressure in SEND, stray response ignored.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'h1234_5678; lsu_req_wstrb = 4'h3; m_req_ready = 1'b0;
    cyc();
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
    m_resp_valid = 1'b1; m_resp_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_m_req_valid", {31'd0, m_req_valid}, 32'd1);
      chk("t3_m_req_addr", m_req_addr, 32'h8000_2000);
      chk("t3_m_req_wdata", m_req_wdata, 32'h1234_5678);
      chk("t3_m_req_wstrb", {28'd0, m_req_wstrb}, 32'h3);
      chk("t3_m_req_wen", {31'd0, m_req_wen}, 32'd1);
      chk("t3_ifu_req_ready", {31'd0, ifu_req_ready}, 32'd0);
      chk("t3_m_resp_ready", {31'd0, m_resp_ready}, 32'd0);
      chk("t3_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd0);
      cyc();
    end
    ifu_req_valid = 1'b0; m_resp_valid = 1'b0;
    mem_txn(32'h0000_0000, 1'b0);

    // 4. Owner stalls the response for three cycles.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0;
    cyc();
    lsu_req_valid = 1'b0;
    send_phase();
    lsu_resp_ready = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_m_resp_ready", {31'd0, m_resp_ready}, 32'd0);
      chk("t4_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd1);
      chk("t4_lsu_resp_data", lsu_resp_data, 32'hCAFE_0001);
      cyc();
    end
    lsu_resp_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
    #1;
    chk("t4_m_resp_ready_hs", {31'd0, m_resp_ready}, 32'd1);
    chk("t4_ifu_req_ready_wait", {31'd0, ifu_req_ready}, 32'd0);
    cyc();
    m_resp_valid = 1'b0;
    #1 chk("t4_ifu_req_ready_idle", {31'd0, ifu_req_ready}, 32'd1);
    cyc();
    ifu_req_valid = 1'b0;
    mem_txn(32'h0000_0013, 1'b0);

    // 5. Error response on an LSU load.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 1'b0;
    cyc();
    lsu_req_valid = 1'b0;
    send_phase();
    m_resp_valid = 1'b1; m_resp_data = 32'h0; m_resp_err = 1'b1;
    #1;
    chk("t5_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd1);
    chk("t5_lsu_resp_err", {31'd0, lsu_resp_err}, 32'd1);
    chk("t5_ifu_resp_err", {31'd0, ifu_resp_err}, 32'd0);
    cyc();
    m_resp_valid = 1'b0; m_resp_err = 1'b0;

    // 6. Reset asserted while waiting for a response.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_000C;
    cyc();
    ifu_req_valid = 1'b0;
    send_phase();
    m_resp_valid = 1'b1; m_resp_data = 32'h0000_0055;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    #1 chk("t6_ifu_resp_valid_pre", {31'd0, ifu_resp_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd0);
    chk("t6_m_resp_ready", {31'd0, m_resp_ready}, 32'd0);
    chk("t6_ifu_req_ready", {31'd0, ifu_req_ready}, 32'd0);
    chk("t6_lsu_req_ready", {31'd0, lsu_req_ready}, 32'd0);
    chk("t6_m_req_valid", {31'd0, m_req_valid}, 32'd0);
    #3 rst = 1'b1;
    m_resp_valid = 1'b0;
    #1 chk("t6_regrant_ready", {31'd0, ifu_req_ready}, 32'd1);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
    chk("t6_m_req_valid_new", {31'd0, m_req_valid}, 32'd1);
    chk("t6_m_req_addr_new", m_req_addr, 32'h8000_0010);
    send_phase();
    m_resp_valid = 1'b1; m_resp_data = 32'h0000_0093;
    #1 chk("t6_ifu_resp_data", ifu_resp_data, 32'h0000_0093);
    cyc();
    m_resp_valid = 1'b0;

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060251_mem_arb.md
# ysyx_23060251_mem_arb

Two-requester memory arbiter for the NPC core. It shares the single downstream memory port between the instruction-fetch path (IFU, read-only) and the load/store path (LSU). It holds one transaction outstanding at a time and routes the response back to the owner. The arbiter sits between the IFU/LSU pipeline stages, which use valid/ready handshakes, and the memory/bus bridge.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid / ifu_req_ready  in/out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid / ifu_resp_ready  out/in  1  IFU response handshake
- ifu_resp_data  out  DATA_W  fetched word
- ifu_resp_err  out  1  bus error
- lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W  address
- lsu_req_wen  in  1  1 = write
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wstrb  in  DATA_W/8  byte strobes
- lsu_resp_valid / lsu_resp_ready, lsu_resp_data, lsu_resp_err  same as the IFU response signals
- m_req_valid / m_req_ready  out/in  1  downstream request handshake
- m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb  out  downstream payload (registered)
- m_resp_valid / m_resp_ready  in/out  1  downstream response handshake
- m_resp_data  in  DATA_W  response data
- m_resp_err  in  1  response error

## Operation
- FSM states: IDLE, SEND, WAIT.
- **IDLE:**
  - If any request is valid, choose a winner (see Configuration).
  - Assert only the winner's req_ready, combinationally, in the same cycle.
  - On that handshake, capture the payload into holding registers, set owner, and go to SEND.
  - IFU requests are captured with wen=0, wdata=0, wstrb=0.
- **SEND:**
  - m_req_valid=1 and the payload is driven from the holding registers.
  - The payload is stable until m_req_ready is seen.
  - On m_req_valid & m_req_ready, go to WAIT.
- **WAIT:**
  - m_resp_valid, data and err are forwarded to the owner's resp_* outputs only.
  - m_resp_ready equals the owner's resp_ready.
  - On the handshake, go to IDLE.
- Outside WAIT: both resp_valid=0 and m_resp_ready=0. A stray m_resp_valid is ignored and not consumed.
- All req_ready outputs are 0 in SEND and WAIT.
- The non-owner's resp_valid is always 0.
- Reset values: state=IDLE; all *_valid and *_ready outputs = 0; holding registers = 0; owner=IFU; rr pointer = LSU-first.
- Reset asserted mid-transaction returns to IDLE immediately. The in-flight transaction is abandoned and no response is delivered.

## Timing
- Request accepted in cycle N means m_req_valid is first high in cycle N+1.
- Response handshake in cycle M means a new grant is possible in cycle M+1, which is IDLE.
- Minimum occupancy is 3 cycles per transaction when downstream readies are 1 and the response returns the cycle after the request.
- Simultaneous valid requests: exactly one is granted per IDLE cycle. The loser keeps its valid and is granted at the next IDLE.
- A requester dropping valid before it is granted is legal and is never granted.

## Configuration
- Macro: YSYX_23060251_ARB_RR_EN.
- **Defined:** round-robin.
  - The 1-bit pointer names the preferred requester.
  - After each accepted request, the pointer moves to the other requester.
  - Under continuous contention, grants alternate IFU/LSU.
- **Undefined:** fixed priority; LSU wins every tie.
  - The pointer register is not instantiated.
  - IFU may starve under continuous LSU traffic, which is accepted behaviour.

## Structure
- Package ysyx_23060251_arb_pkg:
  - state enum {IDLE, SEND, WAIT}
  - owner enum {OWN_IFU, OWN_LSU}
  - width localparams for the default ADDR_W/DATA_W
- One sub-module, ysyx_23060251_arb_pick:
  - Combinational 2-way grant from valid bits and pointer.
  - Round-robin or fixed-priority behaviour is selected by the macro.
- Holding registers, FSM and response routing live in the top module.

## Test plan
1. Single IFU fetch: ifu_req addr=0x8000_0000, m_req_ready=1, m_resp data=0x0000_0413 one cycle later → ifu_resp_valid with data 0x0000_0413 and err=0; lsu_resp_valid stays 0; m_req_addr=0x8000_0000 with wen=0.
2. Simultaneous requests: IFU addr=0x8000_0004 and LSU write addr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF, both valid every cycle for 4 transactions.
   - Macro defined: grant order LSU, IFU, LSU, IFU.
   - Macro undefined: LSU ×4 while IFU waits.
3. Backpressure: m_req_ready=0 for 5 cycles in SEND → payload registers unchanged and no req_ready asserted; m_resp_valid=1 during SEND is not consumed (m_resp_ready=0).
4. Owner stall: in WAIT with lsu_resp_ready=0 for 3 cycles → m_resp_ready=0 and lsu_resp_valid held high with stable data; the handshake happens on the 4th cycle and the FSM is in IDLE the next cycle.
5. Error path: m_resp_err=1 on an LSU load → lsu_resp_err=1 and ifu_resp_err=0.
6. Reset mid-operation: rst low while in WAIT → state=IDLE and all valid/ready outputs 0 asynchronously; after release, a new IFU request is granted normally.
